// File: rtl/conv_pkg.sv
// Shared widths and state encoding for the 32<->8 width converters.
package conv_pkg;

  localparam int CONV_IN_W  = 32;
  localparam int CONV_OUT_W = 8;
  localparam int RATIO      = CONV_IN_W / CONV_OUT_W;
  localparam int CNT_W      = $clog2(RATIO);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } conv_state_t;

endpackage

// File: rtl/conv_32_8.sv
// Word-to-byte serialiser: first byte one cycle after accept, RATIO bytes per word.
// A stalled sink freezes salida/last_out/cnt; a new word is taken on the final byte's edge.
module conv_32_8
  import conv_pkg::*;
#(
  parameter int IN_W      = CONV_IN_W,
  parameter int OUT_W     = CONV_OUT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  entrada,
  output logic             in_ready,
  output logic             valid_out,
  output logic [OUT_W-1:0] salida,
  output logic             last_out,
  input  logic             out_ready
);

  localparam int WR       = IN_W / OUT_W;
  localparam int WC       = (WR > 1) ? $clog2(WR) : 1;
  localparam int SH_W     = IN_W - OUT_W;
  localparam logic [WC-1:0] CNT_LAST = WC'(WR - 1);

  conv_state_t      state;
  logic [WC-1:0]    cnt;
  logic [WC-1:0]    cnt_nxt;
  logic [SH_W-1:0]  shreg;
  logic [OUT_W-1:0] first_byte;
  logic [OUT_W-1:0] next_byte;
  logic [SH_W-1:0]  load_sh;
  logic [SH_W-1:0]  shifted_sh;
  logic             accept;
  logic             advance;

  assign in_ready = reset_L & ((state == IDLE) | ((cnt == CNT_LAST) & out_ready));
  assign accept   = valid_in & in_ready;
  assign advance  = valid_out & out_ready;
  assign cnt_nxt  = cnt + 1'b1;

  // The shift register always presents the next outgoing byte at its head.
  always_comb begin
    first_byte = '0;
    next_byte  = '0;
    load_sh    = '0;
    shifted_sh = '0;
    if (MSB_FIRST) begin
      first_byte = entrada[IN_W-1 -: OUT_W];
      load_sh    = entrada[SH_W-1:0];
      next_byte  = shreg[SH_W-1 -: OUT_W];
      shifted_sh = shreg << OUT_W;
    end else begin
      first_byte = entrada[OUT_W-1:0];
      load_sh    = entrada[IN_W-1:OUT_W];
      next_byte  = shreg[OUT_W-1:0];
      shifted_sh = shreg >> OUT_W;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      salida    <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else if (accept) begin
      state     <= SEND;
      cnt       <= '0;
      shreg     <= load_sh;
      salida    <= first_byte;
      valid_out <= 1'b1;
      last_out  <= (CNT_LAST == '0);
    end else if (advance) begin
      if (cnt != CNT_LAST) begin
        cnt      <= cnt_nxt;
        shreg    <= shifted_sh;
        salida   <= next_byte;
        last_out <= (cnt_nxt == CNT_LAST);
      end else begin
        // salida keeps its stale byte; it is don't-care while valid_out is low.
        state     <= IDLE;
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_32_8.sv
// Directed bench for conv_32_8: per-cycle vector table plus LSB-first and mid-word reset sequences.
module tb_conv_32_8;

  logic        clk;
  logic        reset_L;
  logic        valid_in;
  logic [31:0] entrada;
  logic        out_ready;
  logic        in_ready;
  logic        valid_out;
  logic [7:0]  salida;
  logic        last_out;
  logic        l_in_ready;
  logic        l_valid_out;
  logic [7:0]  l_salida;
  logic        l_last_out;

  int errors = 0;
  int checks = 0;

  conv_32_8 #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .entrada(entrada),
    .in_ready(in_ready), .valid_out(valid_out), .salida(salida),
    .last_out(last_out), .out_ready(out_ready)
  );

  conv_32_8 #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .entrada(entrada),
    .in_ready(l_in_ready), .valid_out(l_valid_out), .salida(l_salida),
    .last_out(l_last_out), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        vi;
    logic [31:0] ent;
    logic        ordy;
    logic        exp_ir;
    logic        exp_vo;
    logic        chk_dat;
    logic [7:0]  exp_sal;
    logic        exp_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic vi, logic [31:0] ent, logic ordy,
                              logic ir, logic vo, logic cd, logic [7:0] sal, logic lst);
    vec_t v;
    v.rst_n = r; v.vi = vi; v.ent = ent; v.ordy = ordy;
    v.exp_ir = ir; v.exp_vo = vo; v.chk_dat = cd; v.exp_sal = sal; v.exp_last = lst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic vi, input logic [31:0] ent, input logic ordy);
    @(negedge clk);
    reset_L = r; valid_in = vi; entrada = ent; out_ready = ordy;
    #1;
  endtask

  logic [7:0] msb_b[4];
  logic [7:0] lsb_b[4];
  logic [7:0] new_b[4];

  initial begin
    reset_L = 1'b0; valid_in = 1'b1; entrada = 32'hFFDD0003; out_ready = 1'b1;

    // reset, then single word
    vecs.push_back(mk(0,1,32'hFFDD0003,1, 0,0,1,8'h00,0));
    vecs.push_back(mk(0,1,32'hFFDD0003,1, 0,0,1,8'h00,0));
    vecs.push_back(mk(1,0,32'h0,1,        1,0,1,8'h00,0));
    vecs.push_back(mk(1,1,32'hFFDD0003,1, 1,0,0,8'h00,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'hFF,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'hDD,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'h00,0));
    vecs.push_back(mk(1,0,32'h0,1,        1,1,1,8'h03,1));
    vecs.push_back(mk(1,0,32'h0,1,        1,0,0,8'h00,0));
    // back-to-back words, entrada changes while first word is in flight
    vecs.push_back(mk(1,1,32'h01020304,1, 1,0,0,8'h00,0));
    vecs.push_back(mk(1,1,32'hA0B0C0D0,1, 0,1,1,8'h01,0));
    vecs.push_back(mk(1,1,32'hA0B0C0D0,1, 0,1,1,8'h02,0));
    vecs.push_back(mk(1,1,32'hA0B0C0D0,1, 0,1,1,8'h03,0));
    vecs.push_back(mk(1,1,32'hA0B0C0D0,1, 1,1,1,8'h04,1));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'hA0,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'hB0,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'hC0,0));
    vecs.push_back(mk(1,0,32'h0,1,        1,1,1,8'hD0,1));
    vecs.push_back(mk(1,0,32'h0,1,        1,0,0,8'h00,0));
    // backpressure on byte 22 (valid_in ignored meanwhile) and on the last byte
    vecs.push_back(mk(1,1,32'h11223344,1, 1,0,0,8'h00,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'h11,0));
    vecs.push_back(mk(1,1,32'hDEADBEEF,0, 0,1,1,8'h22,0));
    vecs.push_back(mk(1,1,32'hDEADBEEF,0, 0,1,1,8'h22,0));
    vecs.push_back(mk(1,0,32'h0,0,        0,1,1,8'h22,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'h22,0));
    vecs.push_back(mk(1,0,32'h0,1,        0,1,1,8'h33,0));
    vecs.push_back(mk(1,0,32'h0,0,        0,1,1,8'h44,1));
    vecs.push_back(mk(1,0,32'h0,1,        1,1,1,8'h44,1));
    vecs.push_back(mk(1,0,32'h0,1,        1,0,0,8'h00,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].vi, vecs[i].ent, vecs[i].ordy);
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ir));
      check($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(vecs[i].exp_vo));
      check($sformatf("vec%0d last_out", i),  32'(last_out),  32'(vecs[i].exp_last));
      if (vecs[i].chk_dat)
        check($sformatf("vec%0d salida", i), 32'(salida), 32'(vecs[i].exp_sal));
    end

    // LSB-first build side by side with MSB-first
    msb_b = '{8'hFF, 8'hDD, 8'h00, 8'h03};
    lsb_b = '{8'h03, 8'h00, 8'hDD, 8'hFF};
    drive(1, 1, 32'hFFDD0003, 1);
    check("lsb in_ready idle", 32'(l_in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h0, 1);
      check($sformatf("pair%0d msb salida", i), 32'(salida), 32'(msb_b[i]));
      check($sformatf("pair%0d lsb salida", i), 32'(l_salida), 32'(lsb_b[i]));
      check($sformatf("pair%0d lsb valid", i), 32'(l_valid_out), 32'd1);
      check($sformatf("pair%0d lsb last", i), 32'(l_last_out), 32'(i == 3));
    end
    drive(1, 0, 32'h0, 1);
    check("lsb valid after word", 32'(l_valid_out), 32'd0);

    // async reset while DD is on salida
    drive(1, 1, 32'hFFDD0003, 1);
    drive(1, 0, 32'h0, 1);
    check("mid FF", 32'(salida), 32'hFF);
    drive(1, 0, 32'h0, 1);
    check("mid DD", 32'(salida), 32'hDD);
    check("mid DD valid", 32'(valid_out), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    check("async rst valid_out", 32'(valid_out), 32'd0);
    check("async rst salida", 32'(salida), 32'h00);
    check("async rst in_ready", 32'(in_ready), 32'd0);
    check("async rst lsb valid", 32'(l_valid_out), 32'd0);
    drive(1, 0, 32'h0, 1);
    check("post rst in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h0, 1);
      check($sformatf("post rst quiet%0d", i), 32'(valid_out), 32'd0);
    end
    new_b = '{8'h55, 8'h66, 8'h77, 8'h88};
    drive(1, 1, 32'h55667788, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h0, 1);
      check($sformatf("new%0d salida", i), 32'(salida), 32'(new_b[i]));
      check($sformatf("new%0d valid", i), 32'(valid_out), 32'd1);
      check($sformatf("new%0d last", i), 32'(last_out), 32'(i == 3));
    end
    drive(1, 0, 32'h0, 1);
    check("new word done", 32'(valid_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
